// File: rtl/slow_clk_monitor_if.sv
// Slow-clock monitor bundle: slow clock in, tick/period/status out.
interface slow_clk_monitor_if #(
    parameter int unsigned CNT_W = 26
);
    logic             slow_in;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             lost;
    logic             period_err;

    // Source side: drives the slow clock, observes monitor results.
    modport master (
        output slow_in,
        input  tick, period, period_vld, locked, lost, period_err
    );

    // Monitor side.
    modport slave (
        input  slow_in,
        output tick, period, period_vld, locked, lost, period_err
    );
endinterface

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: synchronises a slow clock into the clk domain, emits one tick
// per rising edge, measures the rise-to-rise period and tracks lock/loss.
// Optional feature macro: TOLERANCE_CHECK_EN (period compared against
// EXP_PERIOD +/- TOL; an out-of-range period raises period_err and breaks lock).
// Pipeline: slow_in -> sync chain -> history flop -> rise_q -> registered outputs,
// so every output moves SYNC_STAGES+1 edges after the first sample of a high level.
module slow_clk_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned TIMEOUT     = 40000000,
    parameter int unsigned LOCK_EDGES  = 2,
    parameter int unsigned EXP_PERIOD  = 31250000,
    parameter int unsigned TOL         = 312500
) (
    input  logic              clk,
    input  logic              rst_n,
    slow_clk_monitor_if.slave mon_if
);
    localparam int unsigned EDGE_W = $clog2(LOCK_EDGES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        LOST = 2'd3
    } state_e;

    // Elaboration-time sanity checks on the configuration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("slow_clk_monitor: SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT < 2 || 64'(TIMEOUT) >= (64'(1) << CNT_W)) begin : g_bad_timeout
        $error("slow_clk_monitor: TIMEOUT must be in [2, 2**CNT_W)");
    end
    if (LOCK_EDGES < 1) begin : g_bad_lock
        $error("slow_clk_monitor: LOCK_EDGES must be >= 1");
    end
    if (64'(EXP_PERIOD) >= (64'(1) << CNT_W) || TOL >= EXP_PERIOD) begin : g_bad_tol
        $error("slow_clk_monitor: EXP_PERIOD/TOL out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   rise_c;

    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  meas_c;
    logic              timeout_c;
    logic              bad_c;

    state_e            state_q, state_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [EDGE_W-1:0] edge_inc_c;
    logic              lock_hit_c;

    logic              tick_q, tick_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              period_vld_q, period_vld_d;
    logic              locked_q, locked_d;
    logic              lost_q, lost_d;
    logic              period_err_q, period_err_d;

    assign rise_c     = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign meas_c     = per_cnt_q + CNT_W'(1);
    assign timeout_c  = (per_cnt_q == CNT_W'(TIMEOUT - 1)) && !rise_q;
    assign edge_inc_c = edge_cnt_q + EDGE_W'(1);
    assign lock_hit_c = (edge_inc_c >= EDGE_W'(LOCK_EDGES));

`ifdef TOLERANCE_CHECK_EN
    logic [CNT_W-1:0] diff_c;
    assign diff_c = (meas_c > CNT_W'(EXP_PERIOD)) ? (meas_c - CNT_W'(EXP_PERIOD))
                                                  : (CNT_W'(EXP_PERIOD) - meas_c);
    assign bad_c  = (diff_c > CNT_W'(TOL));
`else
    assign bad_c  = 1'b0;
`endif

    // Synchroniser chain, edge history and registered rise strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_if.slow_in};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= rise_c;
        end
    end

    // Period counter: cleared on a rise, otherwise counts up and saturates at TIMEOUT.
    always_comb begin
        per_cnt_d = per_cnt_q;
        if (rise_q) begin
            per_cnt_d = '0;
        end else if (per_cnt_q != CNT_W'(TIMEOUT)) begin
            per_cnt_d = per_cnt_q + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a rise always takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise_q) state_d = ACQ;
            end
            ACQ: begin
                if (rise_q) begin
                    if (!bad_c && lock_hit_c) state_d = LOCK;
                end else if (timeout_c) begin
                    state_d = LOST;
                end
            end
            LOCK: begin
                if (rise_q) begin
                    if (bad_c) state_d = ACQ;
                end else if (timeout_c) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (rise_q) state_d = ACQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs and edge counter.
    always_comb begin
        tick_d       = rise_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        period_err_d = 1'b0;
        locked_d     = locked_q;
        lost_d       = lost_q;
        edge_cnt_d   = edge_cnt_q;
        case (state_q)
            ACQ: begin
                if (rise_q) begin
                    period_d     = meas_c;
                    period_vld_d = 1'b1;
                    period_err_d = bad_c;
                    if (bad_c) begin
                        edge_cnt_d = '0;
                    end else begin
                        edge_cnt_d = edge_inc_c;
                        if (lock_hit_c) locked_d = 1'b1;
                    end
                end else if (timeout_c) begin
                    locked_d   = 1'b0;
                    lost_d     = 1'b1;
                    edge_cnt_d = '0;
                end
            end
            LOCK: begin
                if (rise_q) begin
                    period_d     = meas_c;
                    period_vld_d = 1'b1;
                    period_err_d = bad_c;
                    if (bad_c) begin
                        locked_d   = 1'b0;
                        edge_cnt_d = '0;
                    end
                end else if (timeout_c) begin
                    locked_d   = 1'b0;
                    lost_d     = 1'b1;
                    edge_cnt_d = '0;
                end
            end
            LOST: begin
                if (rise_q) lost_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            tick_q       <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
            period_err_q <= 1'b0;
        end else begin
            per_cnt_q    <= per_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            tick_q       <= tick_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            locked_q     <= locked_d;
            lost_q       <= lost_d;
            period_err_q <= period_err_d;
        end
    end

    assign mon_if.tick       = tick_q;
    assign mon_if.period     = period_q;
    assign mon_if.period_vld = period_vld_q;
    assign mon_if.locked     = locked_q;
    assign mon_if.lost       = lost_q;
    assign mon_if.period_err = period_err_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor (SYNC_STAGES=2, TIMEOUT=64, LOCK_EDGES=2,
// EXP_PERIOD=20, TOL=2). Expectations follow TOLERANCE_CHECK_EN if defined.
module tb_slow_clk_monitor;
    localparam int unsigned CNT_W = 26;
`ifdef TOLERANCE_CHECK_EN
    localparam bit TOL_ON = 1'b1;
`else
    localparam bit TOL_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    slow_clk_monitor_if #(.CNT_W(CNT_W)) bus ();

    slow_clk_monitor #(
        .SYNC_STAGES(2),
        .CNT_W      (CNT_W),
        .TIMEOUT    (64),
        .LOCK_EDGES (2),
        .EXP_PERIOD (20),
        .TOL        (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon_if(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sampling point is 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_flags"}, 32'({bus.tick, bus.period_vld, bus.locked, bus.lost, bus.period_err}), 32'd0);
        check({tag, "_period"}, 32'(bus.period), 32'd0);
    endtask

    // Raise slow_in and advance to the cycle where the rise is visible on outputs.
    task automatic rise4();
        bus.slow_in = 1'b1;
        repeat (4) cyc();
    endtask

    // Complete a period of p cycles started by rise4 (half high, half low).
    task automatic rest(input int p);
        bus.slow_in = 1'b1;
        for (int i = 0; i < p / 2 - 4; i++) begin
            cyc();
            if (i == 0) begin
                check("tick_one_cycle", 32'(bus.tick), 32'd0);
                check("vld_one_cycle", 32'(bus.period_vld), 32'd0);
            end
        end
        bus.slow_in = 1'b0;
        repeat (p - p / 2) cyc();
    endtask

    initial begin
        bus.slow_in = 1'b0;

        // Reset state.
        repeat (5) cyc();
        check_idle("reset");
        rst_n = 1'b1;
        repeat (10) cyc();
        check_idle("post_reset_idle");

        // First rise: tick exactly 3 edges after the sampling edge, nothing else.
        bus.slow_in = 1'b1;
        repeat (3) cyc();
        check("tick_early", 32'(bus.tick), 32'd0);
        cyc();
        check("tick_first", 32'(bus.tick), 32'd1);
        check("first_no_vld", 32'(bus.period_vld), 32'd0);
        check("first_unlocked", 32'(bus.locked), 32'd0);

        // Second rise: first period measurement.
        rest(20);
        rise4();
        check("rise2_tick", 32'(bus.tick), 32'd1);
        check("rise2_vld", 32'(bus.period_vld), 32'd1);
        check("rise2_period", 32'(bus.period), 32'd20);
        check("rise2_unlocked", 32'(bus.locked), 32'd0);

        // Third rise: lock asserted with the period update.
        rest(20);
        rise4();
        check("rise3_vld", 32'(bus.period_vld), 32'd1);
        check("rise3_period", 32'(bus.period), 32'd20);
        check("rise3_locked", 32'(bus.locked), 32'd1);
        check("rise3_err", 32'(bus.period_err), 32'd0);

        // Hold high: no further ticks, loss 64 cycles after the last rise.
        begin
            int nticks = 0;
            for (int i = 0; i < 63; i++) begin
                cyc();
                if (bus.tick) nticks++;
            end
            check("hold_no_tick", 32'(nticks), 32'd0);
        end
        check("pre_timeout_lost", 32'(bus.lost), 32'd0);
        check("pre_timeout_locked", 32'(bus.locked), 32'd1);
        cyc();
        check("timeout_lost", 32'(bus.lost), 32'd1);
        check("timeout_unlocked", 32'(bus.locked), 32'd0);

        // Recovery rise: tick, lost cleared, no period update.
        bus.slow_in = 1'b0;
        repeat (10) cyc();
        rise4();
        check("recov_tick", 32'(bus.tick), 32'd1);
        check("recov_lost", 32'(bus.lost), 32'd0);
        check("recov_no_vld", 32'(bus.period_vld), 32'd0);
        check("recov_period_held", 32'(bus.period), 32'd20);
        rest(20);
        rise4();
        check("recov2_vld", 32'(bus.period_vld), 32'd1);
        check("recov2_unlocked", 32'(bus.locked), 32'd0);
        rest(20);
        rise4();
        check("relock", 32'(bus.locked), 32'd1);

        // Rise on the last cycle before timeout: measured, not lost.
        rest(64);
        rise4();
        check("edge64_lost", 32'(bus.lost), 32'd0);
        check("edge64_vld", 32'(bus.period_vld), 32'd1);
        check("edge64_period", 32'(bus.period), 32'd64);
        check("edge64_err", 32'(bus.period_err), 32'(TOL_ON));
        check("edge64_locked", 32'(bus.locked), 32'(!TOL_ON));
        rest(20);
        rise4();
        rest(20);
        rise4();
        check("relock2", 32'(bus.locked), 32'd1);

        // Out-of-tolerance period, then two slightly long but acceptable ones.
        rest(25);
        rise4();
        check("p25_period", 32'(bus.period), 32'd25);
        check("p25_vld", 32'(bus.period_vld), 32'd1);
        check("p25_err", 32'(bus.period_err), 32'(TOL_ON));
        check("p25_locked", 32'(bus.locked), 32'(!TOL_ON));
        rest(21);
        rise4();
        check("p21a_period", 32'(bus.period), 32'd21);
        check("p21a_err", 32'(bus.period_err), 32'd0);
        check("p21a_locked", 32'(bus.locked), 32'(!TOL_ON));
        rest(21);
        rise4();
        check("p21b_locked", 32'(bus.locked), 32'd1);
        check("p21b_err", 32'(bus.period_err), 32'd0);

        // Asynchronous reset while locked: outputs clear without a clock edge.
        bus.slow_in = 1'b1;
        repeat (5) cyc();
        check("pre_rst_locked", 32'(bus.locked), 32'd1);
        rst_n = 1'b0;
        #2;
        check_idle("async_rst");
        repeat (3) cyc();
        check_idle("rst_held");
        rst_n = 1'b1;
        bus.slow_in = 1'b0;
        repeat (10) cyc();
        rise4();
        check("post_rst_tick", 32'(bus.tick), 32'd1);
        check("post_rst_no_vld", 32'(bus.period_vld), 32'd0);
        check("post_rst_unlocked", 32'(bus.locked), 32'd0);
        rest(20);
        rise4();
        check("post_rst_vld", 32'(bus.period_vld), 32'd1);
        check("post_rst_period", 32'(bus.period), 32'd20);
        check("post_rst_still_unlocked", 32'(bus.locked), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
